// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Execute-to-writeback FIFO holding ALU result, ZERO flag and
//               destination register, presented first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_zero,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_zero,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_err
);

    localparam logic [PTR_WIDTH:0] c_depth = (PTR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic                  r_mem_zero [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];

    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_count;
    logic                  r_ovf;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_overflow;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign out_valid = ~empty;
    assign in_ready  = ~full;
    assign count     = r_count;
    assign ovf_err   = r_ovf;

    assign w_push     = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign w_overflow = in_valid & full & ~w_pop;

    // Head is forced to zero when empty so stale storage never leaks out.
    assign out_data = empty ? '0   : r_mem_data[r_rd_ptr];
    assign out_zero = empty ? 1'b0 : r_mem_zero[r_rd_ptr];
    assign out_addr = empty ? '0   : r_mem_addr[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                // Pointers are PTR_WIDTH wide, so increment wraps modulo DEPTH.
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_zero[r_wr_ptr] <= in_zero;
            r_mem_addr[r_wr_ptr] <= in_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_fifo
// Description : Directed self-checking bench for alu_result_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_zero;
    logic [4:0]  in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic [4:0]  out_addr;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        ovf_err;

    int tests  = 0;
    int errors = 0;

    alu_result_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .DEPTH      (4),
        .PTR_WIDTH  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_zero   (in_zero),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_addr  (out_addr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic z, input logic [4:0] a);
        in_valid = v;
        in_data  = d;
        in_zero  = z;
        in_addr  = a;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        #12;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_ovf",       32'(ovf_err),   32'd0);
        rst_n = 1'b1;
        tick();

        // Fill with four entries, no consumer.
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 32'h11111111 * i, 1'b0, 5'(i));
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("fill_full",     32'(full),     32'd1);
        chk("fill_count",    32'(count),    32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head",     out_data,      32'h11111111);

        // Overflow attempt while full.
        set_in(1'b1, 32'hDEADBEEF, 1'b0, 5'd31);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("ovf_count", 32'(count),   32'd4);
        chk("ovf_flag",  32'(ovf_err), 32'd1);
        chk("ovf_head",  out_data,     32'h11111111);

        // Drain: order must be preserved and 0xDEADBEEF must not appear.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data",  out_data,       32'h11111111 * i);
            chk("drain_addr",  32'(out_addr),  32'(i));
            chk("drain_zero",  32'(out_zero),  32'd0);
            tick();
        end
        chk("drain_empty", 32'(empty),   32'd1);
        chk("drain_data0", out_data,     32'd0);
        chk("drain_ovf",   32'(ovf_err), 32'd1);
        tick();
        chk("empty_pop_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Simultaneous push/pop at COUNT=2, pointers wrap.
        set_in(1'b1, 32'hA0A0A0A0, 1'b0, 5'd2);
        tick();
        set_in(1'b1, 32'hB0B0B0B0, 1'b0, 5'd3);
        tick();
        chk("sim_pre_count", 32'(count), 32'd2);
        set_in(1'b1, 32'h00000000, 1'b1, 5'd7);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                chk("sim_head_a", out_data, 32'hA0A0A0A0);
                chk("sim_addr_a", 32'(out_addr), 32'd2);
            end else if (i == 1) begin
                chk("sim_head_b", out_data, 32'hB0B0B0B0);
                chk("sim_addr_b", 32'(out_addr), 32'd3);
            end else begin
                chk("sim_head_r7", out_data, 32'h0);
                chk("sim_zero_r7", 32'(out_zero), 32'd1);
                chk("sim_addr_r7", 32'(out_addr), 32'd7);
            end
            tick();
            chk("sim_count", 32'(count), 32'd2);
        end
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        tick();
        tick();
        chk("sim_drain_empty", 32'(empty), 32'd1);
        out_ready = 1'b0;

        // Fall-through latency.
        set_in(1'b1, 32'h0000ABCD, 1'b0, 5'd5);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("fwft_valid", 32'(out_valid), 32'd1);
        chk("fwft_data",  out_data,       32'h0000ABCD);
        chk("fwft_addr",  32'(out_addr),  32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fwft_empty", 32'(empty), 32'd1);

        // Flush beats concurrent push and pop.
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 32'hC0000000 + 32'(i), 1'b0, 5'(10 + i));
            tick();
        end
        chk("flush_pre_count", 32'(count), 32'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'hEEEEEEEE, 1'b0, 5'd14);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("flush_count", 32'(count),   32'd0);
        chk("flush_empty", 32'(empty),   32'd1);
        chk("flush_ovf",   32'(ovf_err), 32'd1);
        set_in(1'b1, 32'h12345678, 1'b1, 5'd9);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("post_flush_data",  out_data,      32'h12345678);
        chk("post_flush_addr",  32'(out_addr), 32'd9);
        chk("post_flush_zero",  32'(out_zero), 32'd1);
        chk("post_flush_count", 32'(count),    32'd1);

        // Asynchronous reset mid-stream at COUNT=3.
        set_in(1'b1, 32'h22220000, 1'b0, 5'd20);
        tick();
        set_in(1'b1, 32'h33330000, 1'b0, 5'd21);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("mid_pre_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count",    32'(count),     32'd0);
        chk("mid_rst_empty",    32'(empty),     32'd1);
        chk("mid_rst_outvalid", 32'(out_valid), 32'd0);
        chk("mid_rst_outdata",  out_data,       32'd0);
        chk("mid_rst_inready",  32'(in_ready),  32'd1);
        chk("mid_rst_ovf",      32'(ovf_err),   32'd0);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 32'h55555555, 1'b0, 5'd1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 5'd0);
        chk("post_rst_data",  out_data,    32'h55555555);
        chk("post_rst_count", 32'(count),  32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
